// File: rtl/inst_prefetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry buffer and redirect flush.
// Optional same-cycle bypass of an empty queue: define PIQ_BYPASS_EN.
module inst_prefetch_queue #(
    parameter int NBITS       = 8,
    parameter int NINSTR_BITS = 32,
    parameter int DEPTH       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect,
    input  logic [NBITS-1:0]       redirect_pc,
    output logic                   mem_req,
    output logic [NBITS-1:0]       mem_addr,
    input  logic                   mem_busy,
    input  logic                   mem_valid,
    input  logic [NINSTR_BITS-1:0] mem_rdata,
    output logic                   instr_valid,
    output logic [NINSTR_BITS-1:0] instr,
    output logic [NBITS-1:0]       instr_pc,
    input  logic                   instr_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_t;

    state_t                 state;
    logic [NBITS-1:0]       fetch_pc;
    logic [NBITS-1:0]       req_pc;
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [AW:0]            count;
    logic [NINSTR_BITS-1:0] word_q [DEPTH];
    logic [NBITS-1:0]       pc_q   [DEPTH];

    logic accept;
    logic push;
    logic pop;
    logic head_ok;
    logic bypass;

    // count is sampled before any same-cycle pop, so a full queue never requests
    assign mem_req  = !reset && !redirect && (state == FETCH) && (count < DEPTH_C);
    assign mem_addr = reset ? '0 : fetch_pc;
    assign accept   = mem_req && !mem_busy;
    assign head_ok  = !reset && (count != '0);

`ifdef PIQ_BYPASS_EN
    assign bypass      = !reset && (count == '0) && (state == WAIT) && mem_valid;
    assign instr_valid = head_ok || bypass;
    assign instr       = head_ok ? word_q[rd_ptr] : (bypass ? mem_rdata : '0);
    assign instr_pc    = head_ok ? pc_q[rd_ptr]   : (bypass ? req_pc    : '0);
`else
    assign bypass      = 1'b0;
    assign instr_valid = head_ok;
    assign instr       = head_ok ? word_q[rd_ptr] : '0;
    assign instr_pc    = head_ok ? pc_q[rd_ptr]   : '0;
`endif

    assign pop  = head_ok && instr_ready;
    assign push = (state == WAIT) && mem_valid && !(bypass && instr_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= '0;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~NBITS'(3);
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            state    <= (state == WAIT && !mem_valid) ? DISCARD : FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    if (accept) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + NBITS'(4);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_valid) state <= FETCH;
                end
                DISCARD: begin
                    if (mem_valid) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
            if (push) begin
                word_q[wr_ptr] <= mem_rdata;
                pc_q[wr_ptr]   <= req_pc;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Bench for inst_prefetch_queue: random memory timing, scoreboard of the
// expected fetch-address and instruction streams since the last redirect.
module tb_inst_prefetch_queue;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_busy;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_ready;

`ifdef PIQ_BYPASS_EN
    localparam int FILL_LAT = 1;
`else
    localparam int FILL_LAT = 2;
`endif

    inst_prefetch_queue dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_busy    (mem_busy),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_count = 0;
    int pop_count = 0;
    int first_acc_cyc = -1;
    int first_val_cyc = -1;
    int lat_min = 0;
    int lat_max = 0;
    int busy_pct = 0;
    bit force_busy = 0;

    logic [7:0] exp_acc [$];
    logic [7:0] exp_pop [$];

    initial clock = 0;
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    function automatic logic [31:0] word_of(input logic [7:0] pc);
        return {pc, ~pc, pc ^ 8'h5a, 8'hc3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Reference: after a redirect to t, the fetch stream and the delivered
    // stream are both t, t+4, t+8, ... modulo 256, with t's low bits cleared.
    task automatic set_stream(input logic [7:0] t);
        logic [7:0] p;
        exp_acc.delete();
        exp_pop.delete();
        p = t & 8'hfc;
        for (int i = 0; i < 1024; i++) begin
            exp_acc.push_back(p);
            exp_pop.push_back(p);
            p = p + 8'd4;
        end
    endtask

    task automatic do_redirect(input logic [7:0] t);
        redirect    = 1;
        redirect_pc = t;
        set_stream(t);
        @(posedge clock);
        #1;
        redirect = 0;
    endtask

    // Memory model: one outstanding request, response after lat cycles
    initial begin
        bit         acc;
        bit         pend;
        logic [7:0] a;
        logic [7:0] paddr;
        int         cnt;
        mem_valid = 0;
        mem_busy  = 0;
        mem_rdata = 0;
        pend  = 0;
        paddr = 0;
        cnt   = 0;
        forever begin
            @(negedge clock);
            acc = mem_req && !mem_busy && !reset;
            a   = mem_addr;
            @(posedge clock);
            #2;
            mem_valid = 0;
            mem_rdata = 0;
            if (reset) pend = 0;
            if (acc) begin
                pend  = 1;
                paddr = a;
                cnt   = $urandom_range(lat_max, lat_min);
            end
            if (pend) begin
                if (cnt == 0) begin
                    mem_valid = 1;
                    mem_rdata = word_of(paddr);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            mem_busy = force_busy || ($urandom_range(99, 0) < busy_pct);
        end
    end

    // Monitor
    initial begin
        bit         prev_hold;
        logic [7:0] prev_addr;
        logic [7:0] p;
        prev_hold = 0;
        prev_addr = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_hold = 0;
                chk("rst_mem_req", 32'(mem_req), 0);
                chk("rst_mem_addr", 32'(mem_addr), 0);
                chk("rst_valid", 32'(instr_valid), 0);
                chk("rst_instr", instr, 0);
                chk("rst_pc", 32'(instr_pc), 0);
            end else begin
                if (redirect) chk("req_in_redirect", 32'(mem_req), 0);
                if (mem_req && !mem_busy) begin
                    acc_count++;
                    if (first_acc_cyc < 0) first_acc_cyc = cyc;
                    if (exp_acc.size() == 0) chk("acc_underflow", 1, 0);
                    else chk("fetch_addr", 32'(mem_addr), 32'(exp_acc.pop_front()));
                end
                if (prev_hold && mem_req) chk("addr_hold", 32'(mem_addr), 32'(prev_addr));
                prev_hold = mem_req && mem_busy;
                prev_addr = mem_addr;
                if (instr_valid && first_val_cyc < 0) first_val_cyc = cyc;
                if (!instr_valid) begin
                    chk("idle_instr", instr, 0);
                    chk("idle_pc", 32'(instr_pc), 0);
                end else if (instr_ready && !redirect) begin
                    pop_count++;
                    if (exp_pop.size() == 0) begin
                        chk("pop_underflow", 1, 0);
                    end else begin
                        p = exp_pop.pop_front();
                        chk("instr_pc", 32'(instr_pc), 32'(p));
                        chk("instr_word", instr, word_of(p));
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int a0;
        int held;
        reset       = 1;
        redirect    = 0;
        redirect_pc = 0;
        instr_ready = 1;
        repeat (3) @(posedge clock);
        #1;
        reset = 0;
        set_stream(8'h00);
        first_acc_cyc = -1;
        first_val_cyc = -1;
        repeat (12) @(posedge clock);
        #1;
        chk("fill_latency", 32'(first_val_cyc - first_acc_cyc), 32'(FILL_LAT));

        // Consumer stalled: queue fills to DEPTH and fetching stops
        instr_ready = 0;
        acc_count = 0;
        do_redirect(8'h00);
        repeat (12) @(posedge clock);
        #1;
        chk("full_accepts", 32'(acc_count), 4);
        chk("full_no_req", 32'(mem_req), 0);
        chk("full_valid", 32'(instr_valid), 1);
        pop_count = 0;
        instr_ready = 1;
        repeat (4) @(posedge clock);
        #1;
        chk("drain_pops", 32'(pop_count), 4);

        // Memory busy while request is pending at address 8
        acc_count = 0;
        do_redirect(8'h00);
        n = 0;
        while (acc_count < 2 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("busy_setup", 32'(acc_count >= 2), 1);
        force_busy = 1;
        a0 = acc_count;
        held = 0;
        repeat (4) begin
            @(negedge clock);
            if (mem_req && mem_busy && mem_addr == 8'h08) held++;
        end
        chk("busy_held", 32'(held), 3);
        chk("busy_no_acc", 32'(acc_count), 32'(a0));
        @(posedge clock);
        #1;
        force_busy = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("busy_release_acc", 32'(acc_count), 32'(a0 + 1));

        // Redirect while waiting: the in-flight word must be dropped
        lat_min = 2;
        lat_max = 2;
        repeat (6) @(posedge clock);
        #1;
        a0 = acc_count;
        n = 0;
        while (acc_count == a0 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("wait_setup", 32'(acc_count > a0), 1);
        do_redirect(8'h40);
        repeat (5) begin
            @(negedge clock);
            chk("flush_empty", 32'(instr_valid), 0);
        end
        repeat (15) @(posedge clock);
        #1;

        // Address wrap, low redirect bits ignored
        lat_min = 0;
        lat_max = 1;
        do_redirect(8'hfd);
        repeat (14) @(posedge clock);
        #1;

        // Random traffic
        lat_max = 3;
        busy_pct = 30;
        pop_count = 0;
        repeat (1500) begin
            @(posedge clock);
            #1;
            instr_ready = ($urandom_range(9, 0) < 7);
            if ($urandom_range(99, 0) < 3) do_redirect(8'($urandom_range(255, 0)));
        end
        instr_ready = 1;
        busy_pct = 0;
        repeat (20) @(posedge clock);
        #1;
        chk("progress", 32'(pop_count > 100), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
